// File: rtl/scoreboard_issue.sv
// In-order-preferring issue scoreboard: scans ENTRIES cells (index 0 oldest), picks the
// oldest hazard-free cell, and presents it through a registered valid/ready output stage.
module scoreboard_issue #(
    parameter int ENTRIES = 4
) (
    input  logic                    clock,
    input  logic                    reset_sync,
    input  logic [32*ENTRIES-1:0]   cell_instr,
    input  logic [32*ENTRIES-1:0]   cell_pc,
    input  logic [5*ENTRIES-1:0]    cell_rs1,
    input  logic [5*ENTRIES-1:0]    cell_rs2,
    input  logic [5*ENTRIES-1:0]    cell_rd,
    input  logic [ENTRIES-1:0]      cell_running,
    output logic [ENTRIES-1:0]      start,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [31:0]             issue_instr,
    output logic [31:0]             issue_pc,
    output logic [4:0]              issue_rs1,
    output logic [4:0]              issue_rs2,
    output logic [4:0]              issue_rd,
    input  logic                    wb_valid,
    input  logic [4:0]              wb_rd,
    output logic [31:0]             pending
);

    logic [31:0] instr_a [ENTRIES];
    logic [31:0] pc_a    [ENTRIES];
    logic [4:0]  rs1_a   [ENTRIES];
    logic [4:0]  rs2_a   [ENTRIES];
    logic [4:0]  rd_a    [ENTRIES];

    logic [ENTRIES-1:0] cand;
    logic [ENTRIES-1:0] blocked;
    logic [ENTRIES-1:0] elig;
    logic [ENTRIES-1:0] lowest;
    logic               found;
    logic               can_accept;
    logic               fire;
    logic [31:0]        sel_instr;
    logic [31:0]        sel_pc;
    logic [4:0]         sel_rs1;
    logic [4:0]         sel_rs2;
    logic [4:0]         sel_rd;
    logic [31:0]        pending_next;

    function automatic logic reg_busy(input logic [4:0] r, input logic [31:0] p);
        return (r != 5'd0) && p[r];
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            instr_a[i] = cell_instr[32*i +: 32];
            pc_a[i]    = cell_pc[32*i +: 32];
            rs1_a[i]   = cell_rs1[5*i +: 5];
            rs2_a[i]   = cell_rs2[5*i +: 5];
            rd_a[i]    = cell_rd[5*i +: 5];
        end
    end

    // Older candidates block younger ones even if they are themselves stalled.
    always_comb begin
        cand    = '0;
        blocked = '0;
        elig    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            cand[i] = (instr_a[i] != 32'd0) && !cell_running[i];
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (reg_busy(rs1_a[i], pending) || reg_busy(rs2_a[i], pending) ||
                reg_busy(rd_a[i], pending)) begin
                blocked[i] = 1'b1;
            end
            for (int j = 0; j < ENTRIES; j++) begin
                if (j < i && cand[j]) begin
                    if (rd_a[j] != 5'd0 && (rd_a[j] == rs1_a[i] || rd_a[j] == rs2_a[i] ||
                                            rd_a[j] == rd_a[i])) begin
                        blocked[i] = 1'b1;
                    end
                    if (rd_a[i] != 5'd0 && (rs1_a[j] == rd_a[i] || rs2_a[j] == rd_a[i])) begin
                        blocked[i] = 1'b1;
                    end
                end
            end
            elig[i] = cand[i] && !blocked[i];
        end
    end

    always_comb begin
        lowest    = '0;
        found     = 1'b0;
        sel_instr = '0;
        sel_pc    = '0;
        sel_rs1   = '0;
        sel_rs2   = '0;
        sel_rd    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (elig[i] && !found) begin
                lowest[i] = 1'b1;
                found     = 1'b1;
                sel_instr = instr_a[i];
                sel_pc    = pc_a[i];
                sel_rs1   = rs1_a[i];
                sel_rs2   = rs2_a[i];
                sel_rd    = rd_a[i];
            end
        end
    end

    // Handshake: the output stage holds issue_* stable while issue_valid=1 and
    // issue_ready=0; a transfer happens on any edge where both are 1, and the stage
    // may refill on that same edge.
    assign can_accept = !issue_valid || issue_ready;
    assign fire       = found && can_accept && !reset_sync;
    assign start      = fire ? lowest : '0;

    // Set beats clear when the issued rd matches the retiring writeback.
    always_comb begin
        pending_next = pending;
        if (wb_valid) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (fire && sel_rd != 5'd0) begin
            pending_next[sel_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset_sync) begin
            issue_valid <= 1'b0;
            issue_instr <= '0;
            issue_pc    <= '0;
            issue_rs1   <= '0;
            issue_rs2   <= '0;
            issue_rd    <= '0;
            pending     <= '0;
        end else begin
            if (fire) begin
                issue_valid <= 1'b1;
                issue_instr <= sel_instr;
                issue_pc    <= sel_pc;
                issue_rs1   <= sel_rs1;
                issue_rs2   <= sel_rs2;
                issue_rd    <= sel_rd;
            end else if (issue_valid && issue_ready) begin
                issue_valid <= 1'b0;
            end
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_scoreboard_issue.sv
// Directed bench for scoreboard_issue: driver applies cell vectors and checks start/pending,
// a monitor pops the expected-issue queue on every valid/ready transfer.
module tb_scoreboard_issue;

    localparam int ENTRIES = 4;
    localparam int W = 79;

    logic                  clock = 1'b0;
    logic                  reset_sync;
    logic [32*ENTRIES-1:0] cell_instr;
    logic [32*ENTRIES-1:0] cell_pc;
    logic [5*ENTRIES-1:0]  cell_rs1;
    logic [5*ENTRIES-1:0]  cell_rs2;
    logic [5*ENTRIES-1:0]  cell_rd;
    logic [ENTRIES-1:0]    cell_running;
    logic [ENTRIES-1:0]    start;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [31:0]           issue_pc;
    logic [4:0]            issue_rs1;
    logic [4:0]            issue_rs2;
    logic [4:0]            issue_rd;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [31:0]           pending;

    int n_vec  = 0;
    int n_miss = 0;
    logic [W-1:0] exp_q[$];

    scoreboard_issue #(.ENTRIES(ENTRIES)) dut (
        .clock        (clock),
        .reset_sync   (reset_sync),
        .cell_instr   (cell_instr),
        .cell_pc      (cell_pc),
        .cell_rs1     (cell_rs1),
        .cell_rs2     (cell_rs2),
        .cell_rd      (cell_rd),
        .cell_running (cell_running),
        .start        (start),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_instr  (issue_instr),
        .issue_pc     (issue_pc),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .pending      (pending)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: check start mid-cycle, then mark started cells as running.
    task automatic step(input logic [ENTRIES-1:0] exp_start, input string name);
        logic [ENTRIES-1:0] s;
        @(negedge clock);
        s = start;
        check(name, {28'b0, s}, {28'b0, exp_start});
        @(posedge clock);
        #1;
        cell_running = cell_running | s;
    endtask

    task automatic set_cell(input int i, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        cell_instr[32*i +: 32] = instr;
        cell_pc[32*i +: 32]    = pc;
        cell_rs1[5*i +: 5]     = rs1;
        cell_rs2[5*i +: 5]     = rs2;
        cell_rd[5*i +: 5]      = rd;
        cell_running[i]        = 1'b0;
    endtask

    task automatic expect_issue(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        exp_q.push_back({instr, pc, rs1, rs2, rd});
    endtask

    task automatic clear_cells();
        cell_instr   = '0;
        cell_pc      = '0;
        cell_rs1     = '0;
        cell_rs2     = '0;
        cell_rd      = '0;
        cell_running = '0;
    endtask

    task automatic do_reset();
        reset_sync  = 1'b1;
        issue_ready = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        clear_cells();
        exp_q.delete();
        step('0, "reset_start");
        reset_sync = 1'b0;
    endtask

    // Monitor: every valid/ready transfer must match the head of the expected queue.
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        forever begin
            @(negedge clock);
            if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
                act = {issue_instr, issue_pc, issue_rs1, issue_rs2, issue_rd};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL issue_unexpected: got pc %h instr %h, expected no transfer",
                             issue_pc, issue_instr);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_miss++;
                        $display("FAIL issue_txn: got instr=%h pc=%h rs1=%0d rs2=%0d rd=%0d, expected instr=%h pc=%h rs1=%0d rs2=%0d rd=%0d",
                                 act[78:47], act[46:15], act[14:10], act[9:5], act[4:0],
                                 exp[78:47], exp[46:15], exp[14:10], exp[9:5], exp[4:0]);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        // Reset with occupied cells, then independent pair
        reset_sync  = 1'b1;
        issue_ready = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        clear_cells();
        set_cell(0, 32'h0000_00A1, 32'h0000_0100, 5'd1, 5'd2, 5'd5);
        set_cell(1, 32'h0000_00B2, 32'h0000_0104, 5'd3, 5'd4, 5'd6);
        expect_issue(32'h0000_00A1, 32'h0000_0100, 5'd1, 5'd2, 5'd5);
        expect_issue(32'h0000_00B2, 32'h0000_0104, 5'd3, 5'd4, 5'd6);
        step('0, "start_in_reset");
        check("reset_valid",   {31'b0, issue_valid}, 32'd0);
        check("reset_pending", pending, 32'd0);
        check("reset_pc",      issue_pc, 32'd0);
        check("reset_instr",   issue_instr, 32'd0);
        check("reset_rd",      {27'b0, issue_rd}, 32'd0);
        reset_sync  = 1'b0;
        issue_ready = 1'b1;
        step(4'b0001, "pair_c0");
        check("pair_pending_c0", pending, 32'h0000_0020);
        step(4'b0010, "pair_c1");
        check("pair_pending_c1", pending, 32'h0000_0060);
        check("pair_pc_c1",      issue_pc, 32'h0000_0104);
        step(4'b0000, "pair_drain");
        check("pair_valid_drained", {31'b0, issue_valid}, 32'd0);

        // RAW stall released by writeback
        do_reset();
        set_cell(0, 32'h0000_0011, 32'h0000_0200, 5'd1, 5'd2, 5'd5);
        set_cell(1, 32'h0000_0022, 32'h0000_0204, 5'd5, 5'd3, 5'd8);
        expect_issue(32'h0000_0011, 32'h0000_0200, 5'd1, 5'd2, 5'd5);
        expect_issue(32'h0000_0022, 32'h0000_0204, 5'd5, 5'd3, 5'd8);
        issue_ready = 1'b1;
        step(4'b0001, "raw_c0");
        for (int k = 0; k < 3; k++) step(4'b0000, "raw_stall");
        check("raw_pending_held", pending, 32'h0000_0020);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        step(4'b0000, "raw_wb_no_bypass");
        wb_valid = 1'b0;
        check("raw_pending_clear", pending, 32'd0);
        step(4'b0010, "raw_c1");
        check("raw_valid_c1",   {31'b0, issue_valid}, 32'd1);
        check("raw_pc_c1",      issue_pc, 32'h0000_0204);
        check("raw_pending_c1", pending, 32'h0000_0100);
        step(4'b0000, "raw_drain");
        check("raw_valid_drained", {31'b0, issue_valid}, 32'd0);

        // Backpressure
        do_reset();
        set_cell(0, 32'h0000_0033, 32'h0000_0300, 5'd1, 5'd2, 5'd3);
        set_cell(1, 32'h0000_0044, 32'h0000_0304, 5'd4, 5'd5, 5'd6);
        expect_issue(32'h0000_0033, 32'h0000_0300, 5'd1, 5'd2, 5'd3);
        expect_issue(32'h0000_0044, 32'h0000_0304, 5'd4, 5'd5, 5'd6);
        step(4'b0001, "bp_c0");
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, "bp_hold_start");
            check("bp_pc_hold",    issue_pc, 32'h0000_0300);
            check("bp_valid_hold", {31'b0, issue_valid}, 32'd1);
        end
        issue_ready = 1'b1;
        step(4'b0010, "bp_resume");
        check("bp_pc_resume", issue_pc, 32'h0000_0304);
        step(4'b0000, "bp_drain");
        check("bp_valid_drained", {31'b0, issue_valid}, 32'd0);

        // Set and clear of the same register in one cycle
        do_reset();
        set_cell(0, 32'h0000_0055, 32'h0000_0400, 5'd1, 5'd2, 5'd7);
        expect_issue(32'h0000_0055, 32'h0000_0400, 5'd1, 5'd2, 5'd7);
        issue_ready = 1'b1;
        wb_valid    = 1'b1;
        wb_rd       = 5'd7;
        step(4'b0001, "col_issue");
        wb_valid = 1'b0;
        check("col_pending_set_wins", pending, 32'h0000_0080);
        step(4'b0000, "col_drain");
        check("col_pending_after", pending, 32'h0000_0080);

        // Register x0 never hazards and never pends
        do_reset();
        set_cell(0, 32'h0000_0066, 32'h0000_0500, 5'd1, 5'd2, 5'd0);
        set_cell(1, 32'h0000_0077, 32'h0000_0504, 5'd0, 5'd9, 5'd0);
        expect_issue(32'h0000_0066, 32'h0000_0500, 5'd1, 5'd2, 5'd0);
        expect_issue(32'h0000_0077, 32'h0000_0504, 5'd0, 5'd9, 5'd0);
        issue_ready = 1'b1;
        step(4'b0001, "x0_c0");
        check("x0_pending_c0", pending, 32'd0);
        step(4'b0010, "x0_c1");
        check("x0_pending_c1", pending, 32'd0);
        step(4'b0000, "x0_drain");
        check("x0_valid_drained", {31'b0, issue_valid}, 32'd0);

        // WAR / WAW ordering across four cells
        do_reset();
        set_cell(0, 32'h0000_00A0, 32'h0000_0700, 5'd10, 5'd11, 5'd12);
        set_cell(1, 32'h0000_00A1, 32'h0000_0704, 5'd1,  5'd2,  5'd10);
        set_cell(2, 32'h0000_00A2, 32'h0000_0708, 5'd3,  5'd4,  5'd12);
        set_cell(3, 32'h0000_00A3, 32'h0000_070C, 5'd5,  5'd6,  5'd13);
        expect_issue(32'h0000_00A0, 32'h0000_0700, 5'd10, 5'd11, 5'd12);
        expect_issue(32'h0000_00A1, 32'h0000_0704, 5'd1,  5'd2,  5'd10);
        expect_issue(32'h0000_00A3, 32'h0000_070C, 5'd5,  5'd6,  5'd13);
        expect_issue(32'h0000_00A2, 32'h0000_0708, 5'd3,  5'd4,  5'd12);
        issue_ready = 1'b1;
        step(4'b0001, "order_c0");
        step(4'b0010, "order_c1_war_released");
        step(4'b1000, "order_c3_bypasses_c2");
        check("order_pending", pending, 32'h0000_3400);
        wb_valid = 1'b1;
        wb_rd    = 5'd12;
        step(4'b0000, "order_c2_waw_stall");
        wb_valid = 1'b0;
        check("order_pending_wb", pending, 32'h0000_2400);
        step(4'b0100, "order_c2");
        check("order_pending_c2", pending, 32'h0000_3400);
        step(4'b0000, "order_drain");

        // Reset while the output stage holds a transfer
        do_reset();
        set_cell(0, 32'h0000_0088, 32'h0000_0600, 5'd1, 5'd2, 5'd5);
        expect_issue(32'h0000_0088, 32'h0000_0600, 5'd1, 5'd2, 5'd5);
        step(4'b0001, "rst_c0");
        check("rst_valid_held",   {31'b0, issue_valid}, 32'd1);
        check("rst_pending_held", pending, 32'h0000_0020);
        set_cell(1, 32'h0000_0099, 32'h0000_0604, 5'd3, 5'd4, 5'd6);
        reset_sync = 1'b1;
        exp_q.delete();
        step(4'b0000, "rst_start_c1");
        check("rst_valid_dropped", {31'b0, issue_valid}, 32'd0);
        check("rst_pending_clear", pending, 32'd0);
        check("rst_pc_clear",      issue_pc, 32'd0);
        step(4'b0000, "rst_start_c2");
        reset_sync  = 1'b0;
        issue_ready = 1'b1;
        expect_issue(32'h0000_0099, 32'h0000_0604, 5'd3, 5'd4, 5'd6);
        step(4'b0010, "rst_resume");
        check("rst_pc_resume", issue_pc, 32'h0000_0604);
        step(4'b0000, "rst_drain");
        check("rst_valid_drained", {31'b0, issue_valid}, 32'd0);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/scoreboard_issue.md
SCOREBOARD_ISSUE -- requirements
Module: scoreboard_issue

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, giving the number of scoreboard cells scanned; index 0 is the oldest cell.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_sync, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port cell_instr, input, 32*ENTRIES, the flattened instruction word of each cell; cell i occupies bits [32i+31:32i].
REQ-005 SHALL have port cell_pc, input, 32*ENTRIES, the flattened PC of each cell.
REQ-006 SHALL have ports cell_rs1, cell_rs2 and cell_rd, each input, 5*ENTRIES, the flattened register indices of each cell.
REQ-007 SHALL have port cell_running, input, ENTRIES, the per-cell running flags.
REQ-008 SHALL have port start, output, ENTRIES, a one-hot issue strobe to the cells; it is combinational and valid in the issuing cycle.
REQ-009 SHALL have ports issue_valid, output, 1, and issue_ready, input, 1, forming the valid/ready handshake to the execution unit.
REQ-010 SHALL have port issue_instr, output, 32, the issued instruction word.
REQ-011 SHALL have port issue_pc, output, 32, the issued PC.
REQ-012 SHALL have ports issue_rs1, issue_rs2 and issue_rd, each output, 5, the issued register indices.
REQ-013 SHALL have ports wb_valid, input, 1, and wb_rd, input, 5, the writeback notification that retires a destination register.
REQ-014 SHALL have port pending, output, 32, the registered bitmap of destination registers currently in flight.

Function
REQ-015 Cell i SHALL be occupied when cell_instr[i] is not equal to 0.
REQ-016 Cell i SHALL be a candidate when it is occupied and cell_running[i] is 0.
REQ-017 Candidate i SHALL be eligible only if no nonzero operand (rs1, rs2 or rd) of cell i has its bit set in the registered pending bitmap.
REQ-018 Candidate i SHALL be eligible only if no older candidate j<i has a nonzero rd equal to cell i's rs1, rs2 or rd (RAW/WAW), and no older candidate j<i has a nonzero rs1 or rs2 equal to cell i's rd (WAR).
REQ-019 Register index 0 SHALL never create a hazard; pending[0] SHALL always read 0.
REQ-020 Selection SHALL pick the lowest-index eligible cell.
REQ-021 The output stage SHALL be able to accept when issue_valid is 0, or when issue_valid and issue_ready are both 1.
REQ-022 An issue SHALL fire when at least one cell is eligible and the output stage can accept; no issue SHALL fire in any other cycle.
REQ-023 In a firing cycle, start SHALL be one-hot at the selected index; in every other cycle, start SHALL be all zero.
REQ-024 On the clock edge ending a firing cycle, the output registers SHALL load the selected cell's fields and issue_valid SHALL be set to 1.
REQ-025 On that same edge, pending[rd] SHALL be set if the selected rd is not 0.
REQ-026 When issue_valid and issue_ready are both 1 and no issue fires, issue_valid SHALL clear to 0 on the next edge.
REQ-027 While issue_valid is 1 and issue_ready is 0, all issue_* outputs SHALL hold stable.
REQ-028 Back-to-back issue SHALL be supported, giving a throughput of 1 instruction per cycle while issue_ready is held at 1.
REQ-029 The latency from a cell becoming eligible to the corresponding issue_valid rising SHALL be 1 cycle.
REQ-030 When wb_valid is 1 and wb_rd is not 0, pending[wb_rd] SHALL clear on the next edge.
REQ-031 If a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-032 Eligibility SHALL use only the registered pending bitmap; a same-cycle writeback SHALL NOT bypass into eligibility.
REQ-033 A writeback to a register whose pending bit is already clear SHALL be ignored without error.
REQ-034 A cell whose running flag is 1 SHALL never be selected, so an instruction is never issued twice.

Reset
REQ-035 While reset_sync is 1, start SHALL be all zero and no issue SHALL fire, regardless of the cell inputs.
REQ-036 At the edge where reset_sync is 1, issue_valid, every issue_* field and pending SHALL all become 0.
REQ-037 A reset that occurs mid-handshake SHALL drop the held output without asserting any start strobe.
REQ-038 Selection SHALL resume on the first cycle after reset_sync deasserts.

Verification
REQ-039 The bench SHALL cover an independent pair: cell0 = (rd=5, rs1=1, rs2=2) and cell1 = (rd=6, rs1=3, rs2=4), with issue_ready held at 1 -> start=0001 in cycle 0, start=0010 in cycle 1, and then pending bits 5 and 6 set.
REQ-040 The bench SHALL cover a RAW stall: cell0 has rd=5 and cell1 has rs1=5 -> cell1 is not issued until wb_valid with wb_rd=5 arrives, and it issues exactly 1 cycle after pending[5] clears.
REQ-041 The bench SHALL cover backpressure: issue_ready=0 for 3 cycles while issue_valid=1 -> issue_pc stays constant, start stays 0000, and issue resumes on the cycle issue_ready becomes 1.
REQ-042 The bench SHALL cover a same-cycle collision: issue rd=7 while wb_valid=1 with wb_rd=7 -> pending[7] reads 1 afterwards.
REQ-043 The bench SHALL cover register x0: cell0 has rd=0 and cell1 has rs1=0 -> both issue back-to-back and pending stays 0.
REQ-044 The bench SHALL cover reset while issue_valid=1 and pending=0x00000020 -> issue_valid=0, pending=0 and start=0000 on the following cycle.
